// File: rtl/crc32_pkg.sv
// Shared constants and state encoding for the streaming CRC-32 engine.
package crc32_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        FCS  = 2'd2
    } crc_state_t;

    // Side-band flags carried alongside every output beat.
    typedef struct packed {
        logic sof;
        logic eof;
        logic fcs;
    } beat_flags_t;

endpackage

// File: rtl/crc32_next.sv
// Combinational CRC-32 step: folds DATA_W bits into the register, bit 0 first,
// MSB-first Galois form.
module crc32_next
    import crc32_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [31:0]       crc,
    input  logic [DATA_W-1:0] data,
    output logic [31:0]       crc_nxt
);

    logic [31:0] c;

    // Unrolled bit-serial update, wire-order bit 0 first.
    always_comb begin
        c = crc;
        for (int i = 0; i < DATA_W; i++) begin
            c = {c[30:0], 1'b0} ^ ((data[i] ^ c[31]) ? CRC32_POLY : 32'h0);
        end
        crc_nxt = c;
    end

endmodule

// File: rtl/crc32_stream.sv
// Streaming Ethernet CRC-32 engine, 4- or 8-bit beats.
// Generate mode forwards the payload then appends the FCS; check mode forwards
// the frame and compares the residue.
// Optional build macro CRC32_STREAM_STATS_EN adds FrameCnt/ErrCnt counters.
module crc32_stream
    import crc32_pkg::*;
#(
    parameter  int DATA_W    = 8,
    localparam int FCS_BEATS = 32 / DATA_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              InValid,
    output logic              InReady,
    input  logic [DATA_W-1:0] InData,
    input  logic              InSof,
    input  logic              InEof,
    input  logic              ChkMode,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] OutData,
    output logic              OutSof,
    output logic              OutEof,
    output logic              OutFcs,
    output logic [31:0]       Crc,
    output logic              CrcDone,
    output logic              CrcOk
`ifdef CRC32_STREAM_STATS_EN
    ,
    output logic [15:0]       FrameCnt,
    output logic [15:0]       ErrCnt
`endif
);

    if (DATA_W != 4 && DATA_W != 8) begin : g_bad_width
        $error("crc32_stream: DATA_W must be 4 or 8");
    end

    localparam int                CNT_W    = $clog2(FCS_BEATS) + 1;
    localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(FCS_BEATS - 1);
    localparam logic [CNT_W-1:0] FCS_END  = CNT_W'(FCS_BEATS);

    crc_state_t        state, state_nxt;
    logic              mode;
    logic              chk_pend;
    logic [CNT_W-1:0]  fcs_cnt;
    beat_flags_t       oflags;

    logic              out_free, acc;
    logic              frame_beat, eff_mode, out_eof, pend_set;
    logic              fcs_emit, fcs_last_taken, gen_done;
    logic [31:0]       crc_base, crc_nxt;
    logic [DATA_W-1:0] fcs_data;

    assign out_free       = ~OutValid | OutReady;
    assign InReady        = out_free & (state != FCS);
    assign acc            = InValid & InReady;
    assign fcs_emit       = (state == FCS) & out_free & (fcs_cnt != FCS_END);
    assign fcs_last_taken = OutValid & OutReady & OutFcs & OutEof;

    assign OutSof = oflags.sof;
    assign OutEof = oflags.eof;
    assign OutFcs = oflags.fcs;

    // A SOF beat restarts from the init value before its own bits are folded.
    assign crc_base = InSof ? CRC32_INIT : Crc;

    crc32_next #(.DATA_W(DATA_W)) u_next (
        .crc     (crc_base),
        .data    (InData),
        .crc_nxt (crc_nxt)
    );

    // FCS beat: complemented register, MSB first on the wire.
    always_comb begin
        fcs_data = '0;
        for (int i = 0; i < DATA_W; i++) begin
            fcs_data[i] = ~Crc[31-i];
        end
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and per-cycle control decode.
    always_comb begin
        state_nxt  = state;
        frame_beat = 1'b0;
        eff_mode   = InSof ? ChkMode : mode;
        out_eof    = 1'b0;
        pend_set   = 1'b0;
        gen_done   = 1'b0;
        case (state)
            IDLE, DATA: begin
                // In IDLE only a SOF beat opens a frame; stray beats are dropped.
                if (acc && (InSof || state == DATA)) begin
                    frame_beat = 1'b1;
                    if (InEof) begin
                        out_eof   = eff_mode;
                        pend_set  = eff_mode;
                        state_nxt = eff_mode ? IDLE : FCS;
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            FCS: begin
                if (fcs_last_taken) begin
                    gen_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // CRC register, frame bookkeeping, output stage and result flags.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Crc      <= CRC32_INIT;
            mode     <= 1'b0;
            chk_pend <= 1'b0;
            fcs_cnt  <= '0;
            OutValid <= 1'b0;
            OutData  <= '0;
            oflags   <= '0;
            CrcDone  <= 1'b0;
            CrcOk    <= 1'b0;
        end else begin
            CrcDone  <= 1'b0;
            chk_pend <= pend_set;
            // Check result is taken from the registered post-EOF CRC.
            if (chk_pend) begin
                CrcDone <= 1'b1;
                CrcOk   <= (Crc == CRC32_RESIDUE);
            end
            if (gen_done) begin
                CrcDone <= 1'b1;
                CrcOk   <= 1'b1;
            end

            if (frame_beat) begin
                Crc     <= crc_nxt;
                mode    <= eff_mode;
                fcs_cnt <= '0;
            end else if (fcs_emit) begin
                Crc     <= Crc << DATA_W;
                fcs_cnt <= fcs_cnt + CNT_W'(1);
            end

            // Output register only advances when downstream can take it.
            if (out_free) begin
                OutValid <= frame_beat | fcs_emit;
                if (frame_beat) begin
                    OutData <= InData;
                    oflags  <= '{sof: InSof, eof: out_eof, fcs: 1'b0};
                end else if (fcs_emit) begin
                    OutData <= fcs_data;
                    oflags  <= '{sof: 1'b0, eof: (fcs_cnt == FCS_LAST), fcs: 1'b1};
                end else begin
                    oflags  <= '0;
                end
            end
        end
    end

`ifdef CRC32_STREAM_STATS_EN
    // Saturating frame and error counters, stepped on each result pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            FrameCnt <= '0;
            ErrCnt   <= '0;
        end else if (CrcDone) begin
            if (FrameCnt != 16'hFFFF) FrameCnt <= FrameCnt + 16'd1;
            if (!CrcOk && ErrCnt != 16'hFFFF) ErrCnt <= ErrCnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_crc32_stream.sv
// Directed bench for crc32_stream: an 8-bit and a 4-bit instance side by side.
module tb_crc32_stream;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // 8-bit instance signals
    logic        a_v, a_rdy, a_sof, a_eof, a_mode, a_ov, a_ordy, a_osof, a_oeof, a_ofcs, a_done, a_ok;
    logic [7:0]  a_d, a_od;
    logic [31:0] a_crc;
    // 4-bit instance signals
    logic        b_v, b_rdy, b_sof, b_eof, b_mode, b_ov, b_ordy, b_osof, b_oeof, b_ofcs, b_done, b_ok;
    logic [3:0]  b_d, b_od;
    logic [31:0] b_crc;
`ifdef CRC32_STREAM_STATS_EN
    logic [15:0] a_fc, a_ec, b_fc, b_ec;
`endif

    crc32_stream #(.DATA_W(8)) u8 (
        .Clk(Clk), .Reset(Reset), .InValid(a_v), .InReady(a_rdy), .InData(a_d),
        .InSof(a_sof), .InEof(a_eof), .ChkMode(a_mode), .OutValid(a_ov), .OutReady(a_ordy),
        .OutData(a_od), .OutSof(a_osof), .OutEof(a_oeof), .OutFcs(a_ofcs), .Crc(a_crc),
        .CrcDone(a_done), .CrcOk(a_ok)
`ifdef CRC32_STREAM_STATS_EN
        , .FrameCnt(a_fc), .ErrCnt(a_ec)
`endif
    );

    crc32_stream #(.DATA_W(4)) u4 (
        .Clk(Clk), .Reset(Reset), .InValid(b_v), .InReady(b_rdy), .InData(b_d),
        .InSof(b_sof), .InEof(b_eof), .ChkMode(b_mode), .OutValid(b_ov), .OutReady(b_ordy),
        .OutData(b_od), .OutSof(b_osof), .OutEof(b_oeof), .OutFcs(b_ofcs), .Crc(b_crc),
        .CrcDone(b_done), .CrcOk(b_ok)
`ifdef CRC32_STREAM_STATS_EN
        , .FrameCnt(b_fc), .ErrCnt(b_ec)
`endif
    );

    // Output capture: {sof, eof, fcs, data} per transferred beat, plus result pulses.
    logic [10:0] qa[$];
    logic [6:0]  qb[$];
    int   a_ndone = 0, b_ndone = 0, a_done_cyc = 0, a_acc_cyc = 0;
    logic a_lastok = 1'b0, b_lastok = 1'b0;

    always @(negedge Clk) begin
        if (!Reset && a_ov && a_ordy) qa.push_back({a_osof, a_oeof, a_ofcs, a_od});
        if (!Reset && b_ov && b_ordy) qb.push_back({b_osof, b_oeof, b_ofcs, b_od});
        if (a_done) begin
            a_ndone    <= a_ndone + 1;
            a_lastok   <= a_ok;
            a_done_cyc <= cyc;
        end
        if (b_done) begin
            b_ndone  <= b_ndone + 1;
            b_lastok <= b_ok;
        end
    end

    logic [7:0] msg [0:8] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    logic [7:0] fcs [0:3] = '{8'h26, 8'h39, 8'hF4, 8'hCB};
    logic [3:0] fcsn[0:7] = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};
    logic [7:0] frm [0:12];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All drive tasks start and return at posedge+1.
    task automatic send8(input logic [7:0] d, input logic sof, input logic eof, input logic mode);
        int n = 0;
        a_v = 1'b1; a_d = d; a_sof = sof; a_eof = eof; a_mode = mode;
        @(negedge Clk);
        while (!a_rdy && n < 50) begin @(negedge Clk); n++; end
        if (!a_rdy) chk("u8 InReady timeout", {31'b0, a_rdy}, 32'd1);
        a_acc_cyc = cyc;
        @(posedge Clk); #1;
        a_v = 1'b0; a_sof = 1'b0; a_eof = 1'b0;
    endtask

    task automatic send4(input logic [3:0] d, input logic sof, input logic eof, input logic mode);
        int n = 0;
        b_v = 1'b1; b_d = d; b_sof = sof; b_eof = eof; b_mode = mode;
        @(negedge Clk);
        while (!b_rdy && n < 50) begin @(negedge Clk); n++; end
        if (!b_rdy) chk("u4 InReady timeout", {31'b0, b_rdy}, 32'd1);
        @(posedge Clk); #1;
        b_v = 1'b0; b_sof = 1'b0; b_eof = 1'b0;
    endtask

    task automatic wait_done(input bit use4, input int d0, input string tag);
        int n = 0;
        while ((use4 ? b_ndone : a_ndone) == d0 && n < 100) begin @(negedge Clk); #1; n++; end
        chk(tag, use4 ? b_ndone - d0 : a_ndone - d0, 32'd1);
        @(posedge Clk); #1;
    endtask

    // Expected 8-bit generate-mode output: 9 payload bytes then 4 FCS bytes.
    task automatic chk_gen8(input string tag);
        logic [10:0] e;
        chk({tag, " beats"}, qa.size(), 32'd13);
        for (int i = 0; i < 13; i++) begin
            if (i < 9) e = {i == 0, 1'b0, 1'b0, msg[i]};
            else       e = {1'b0, i == 12, 1'b1, fcs[i-9]};
            if (i < qa.size()) chk($sformatf("%s beat%0d", tag, i), {21'b0, qa[i]}, {21'b0, e});
        end
    endtask

    initial begin
        int d0, bad, n;
        a_v = 0; a_d = 0; a_sof = 0; a_eof = 0; a_mode = 0; a_ordy = 1;
        b_v = 0; b_d = 0; b_sof = 0; b_eof = 0; b_mode = 0; b_ordy = 1;
        for (int i = 0; i < 13; i++) frm[i] = (i < 9) ? msg[i] : fcs[i-9];

        // Reset state
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst crc8", a_crc, 32'hFFFFFFFF);
        chk("rst ovalid8", {31'b0, a_ov}, 32'd0);
        chk("rst flags8", {29'b0, a_osof, a_oeof, a_ofcs}, 32'd0);
        chk("rst odata8", {24'b0, a_od}, 32'd0);
        chk("rst done/ok8", {30'b0, a_done, a_ok}, 32'd0);
        chk("rst crc4", b_crc, 32'hFFFFFFFF);
        chk("rst ovalid4", {31'b0, b_ov}, 32'd0);
        @(posedge Clk); #1; Reset = 0;
        @(posedge Clk); #1;

        // Beat without SOF in IDLE is dropped and leaves the CRC alone
        qa.delete();
        send8(8'hAA, 0, 0, 0);
        repeat (2) @(posedge Clk); #1;
        chk("idle drop beats", qa.size(), 32'd0);
        chk("idle drop crc", a_crc, 32'hFFFFFFFF);

        // Generate mode, 8-bit, "123456789"
        d0 = a_ndone;
        for (int i = 0; i < 9; i++) send8(msg[i], i == 0, i == 8, 0);
        chk("gen8 crc", a_crc, 32'h9B63D02C);
        wait_done(0, d0, "gen8 done");
        chk_gen8("gen8");
        chk("gen8 ok", {31'b0, a_lastok}, 32'd1);

        Reset = 1; @(posedge Clk); #1; Reset = 0;

        // Check mode, good frame
        qa.delete(); d0 = a_ndone;
        for (int i = 0; i < 13; i++) send8(frm[i], i == 0, i == 12, 1);
        chk("chk good crc", a_crc, 32'hC704DD7B);
        wait_done(0, d0, "chk good done");
        chk("chk good ok", {31'b0, a_lastok}, 32'd1);
        if (qa.size() == 13) chk("chk good last flags", {29'b0, qa[12][10:8]}, 32'b010);

        // Check mode, bit 0 of '5' flipped
        d0 = a_ndone;
        for (int i = 0; i < 13; i++) send8((i == 4) ? (frm[i] ^ 8'h01) : frm[i], i == 0, i == 12, 1);
        wait_done(0, d0, "chk bad done");
        chk("chk bad ok", {31'b0, a_lastok}, 32'd0);
`ifdef CRC32_STREAM_STATS_EN
        chk("stats frames", {16'b0, a_fc}, 32'd2);
        chk("stats errors", {16'b0, a_ec}, 32'd1);
`endif

        // Generate mode with random stalls during FCS
        qa.delete(); d0 = a_ndone; bad = 0; n = 0;
        for (int i = 0; i < 9; i++) send8(msg[i], i == 0, i == 8, 0);
        while (a_ndone == d0 && n < 200) begin
            a_ordy = 1'($urandom_range(0, 1));
            @(negedge Clk); #1;
            if (a_ndone == d0 && a_rdy) bad++;
            @(posedge Clk); #1;
            n++;
        end
        a_ordy = 1;
        @(posedge Clk); #1;
        chk("bp done", a_ndone - d0, 32'd1);
        chk("bp inready during fcs", bad, 32'd0);
        chk_gen8("bp");
        chk("bp ok", {31'b0, a_lastok}, 32'd1);

        // SOF mid-frame aborts the first frame; the restarted frame must check clean
        qa.delete(); d0 = a_ndone;
        for (int i = 0; i < 3; i++) send8(msg[i], i == 0, 0, 1);
        for (int i = 0; i < 13; i++) send8(frm[i], i == 0, i == 12, 1);
        wait_done(0, d0, "abort done");
        chk("abort ok", {31'b0, a_lastok}, 32'd1);
        chk("abort beats", qa.size(), 32'd16);

        // Reset in the middle of a frame
        d0 = a_ndone;
        send8(8'h31, 1, 0, 1);
        send8(8'h32, 0, 0, 1);
        Reset = 1;
        @(posedge Clk); @(negedge Clk);
        chk("midrst crc", a_crc, 32'hFFFFFFFF);
        chk("midrst ovalid", {31'b0, a_ov}, 32'd0);
        chk("midrst ok", {31'b0, a_ok}, 32'd0);
        @(posedge Clk); #1; Reset = 0;
        repeat (4) @(posedge Clk); #1;
        chk("midrst no done", a_ndone - d0, 32'd0);

        // Single-beat check frame of 00
        d0 = a_ndone;
        send8(8'h00, 1, 1, 1);
        wait_done(0, d0, "single done");
        chk("single latency", a_done_cyc - a_acc_cyc, 32'd2);
        chk("single ok", {31'b0, a_lastok}, 32'd0);

        // Generate mode, 4-bit, nibbles low first
        qb.delete(); d0 = b_ndone;
        for (int i = 0; i < 9; i++) begin
            send4(msg[i][3:0], i == 0, 0, 0);
            send4(msg[i][7:4], 0, i == 8, 0);
        end
        chk("gen4 crc", b_crc, 32'h9B63D02C);
        wait_done(1, d0, "gen4 done");
        chk("gen4 beats", qb.size(), 32'd26);
        bad = 0;
        foreach (qb[i]) if (qb[i][4]) bad++;
        chk("gen4 fcs beats", bad, 32'd8);
        for (int i = 0; i < 8; i++)
            if (18 + i < qb.size())
                chk($sformatf("gen4 fcs%0d", i), {25'b0, qb[18+i]}, {25'b0, 1'b0, i == 7, 1'b1, fcsn[i]});
        chk("gen4 ok", {31'b0, b_lastok}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
